// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the CPU datapath (slave).
// mem_req is held for the whole MEM phase; the access completes on the first cycle mem_ready=1.
interface cpu_control_fsm_if #(
   parameter int RCNT_W = 16
);
   logic              en;
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic              zero;
   logic              mem_ready;
   logic              pc_write;
   logic              ir_write;
   logic              reg_dst;
   logic              reg_write;
   logic              alu_src;
   logic              branch;
   logic              jump;
   logic              mem_write;
   logic              mem_req;
   logic              mem_to_reg;
   logic [3:0]        alu_ctrl;
   logic              illegal_op;
   logic              instr_done;
   logic [RCNT_W-1:0] retired;
   logic [2:0]        state_dbg;

   modport master (
      input  en, opcode, funct, zero, mem_ready,
      output pc_write, ir_write, reg_dst, reg_write, alu_src, branch, jump,
             mem_write, mem_req, mem_to_reg, alu_ctrl, illegal_op, instr_done,
             retired, state_dbg
   );

   modport slave (
      output en, opcode, funct, zero, mem_ready,
      input  pc_write, ir_write, reg_dst, reg_write, alu_src, branch, jump,
             mem_write, mem_req, mem_to_reg, alu_ctrl, illegal_op, instr_done,
             retired, state_dbg
   );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky
// TRAP state for unsupported instructions and a wrapping retired-instruction counter.
module cpu_control_fsm #(
   parameter int RCNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   cpu_control_fsm_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;

   state_t            state, state_nxt;
   logic [5:0]        op_q, funct_q;
   logic [RCNT_W-1:0] retired_q;
   logic              funct_ok, op_ok, retire, wr_ok;
   logic [3:0]        rtype_alu;

   // Raw (ungated) control lines
   logic pc_w, ir_w, rd, rw, as, br, jmp, mw, mr, m2r, ill;
   logic [3:0] alu;

   always_comb begin
      funct_ok = 1'b0;
      case (bus.funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
         default: funct_ok = 1'b0;
      endcase
      op_ok = 1'b0;
      case (bus.opcode)
         OP_RTYPE:                          op_ok = funct_ok;
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
         default:                           op_ok = 1'b0;
      endcase
   end

   always_comb begin
      rtype_alu = ALU_AND;
      case (funct_q)
         FN_ADD:  rtype_alu = ALU_ADD;
         FN_SUB:  rtype_alu = ALU_SUB;
         FN_AND:  rtype_alu = ALU_AND;
         FN_OR:   rtype_alu = ALU_OR;
         FN_SLT:  rtype_alu = ALU_SLT;
         default: rtype_alu = ALU_AND;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: state_nxt = op_ok ? S_EXEC : S_TRAP;
         S_EXEC: begin
            case (op_q)
               OP_RTYPE, OP_ADDI: state_nxt = S_WB;
               OP_LW, OP_SW:      state_nxt = S_MEM;
               default:           state_nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (bus.mem_ready) state_nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
         end
         S_WB:    state_nxt = S_FETCH;
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_FETCH;
      endcase
   end

   // Only EXEC/MEM/WB can finish an instruction; DECODE never returns to FETCH.
   assign retire = bus.en && (state_nxt == S_FETCH) &&
                   ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_FETCH;
         op_q      <= '0;
         funct_q   <= '0;
         retired_q <= '0;
      end else if (bus.en) begin
         state <= state_nxt;
         if (state == S_DECODE) begin
            op_q    <= bus.opcode;
            funct_q <= bus.funct;
         end
         if (retire) retired_q <= retired_q + RCNT_W'(1);
      end
   end

   always_comb begin
      pc_w = 1'b0; ir_w = 1'b0; rd = 1'b0; rw = 1'b0; as = 1'b0; br = 1'b0;
      jmp = 1'b0; mw = 1'b0; mr = 1'b0; m2r = 1'b0; ill = 1'b0;
      alu = ALU_AND;
      case (state)
         S_FETCH: begin
            ir_w = 1'b1;
            pc_w = 1'b1;
            alu  = ALU_ADD;
         end
         S_EXEC: begin
            case (op_q)
               OP_RTYPE: begin
                  rd  = 1'b1;
                  alu = rtype_alu;
               end
               OP_ADDI, OP_LW, OP_SW: begin
                  as  = 1'b1;
                  alu = ALU_ADD;
               end
               OP_BEQ: begin
                  alu  = ALU_SUB;
                  br   = 1'b1;
                  pc_w = bus.zero;
               end
               OP_J: begin
                  jmp  = 1'b1;
                  pc_w = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mr = 1'b1;
            as = 1'b1;
            mw = (op_q == OP_SW);
         end
         S_WB: begin
            rw  = 1'b1;
            rd  = (op_q == OP_RTYPE);
            m2r = (op_q == OP_LW);
         end
         S_TRAP:  ill = 1'b1;
         default: ;
      endcase
   end

   // Write-type enables drop while frozen; decoded selects stay visible.
   assign wr_ok = rst && bus.en;

   assign bus.pc_write   = wr_ok && pc_w;
   assign bus.ir_write   = wr_ok && ir_w;
   assign bus.reg_write  = wr_ok && rw;
   assign bus.mem_write  = wr_ok && mw;
   assign bus.mem_req    = wr_ok && mr;
   assign bus.reg_dst    = rst && rd;
   assign bus.alu_src    = rst && as;
   assign bus.branch     = rst && br;
   assign bus.jump       = rst && jmp;
   assign bus.mem_to_reg = rst && m2r;
   assign bus.illegal_op = rst && ill;
   assign bus.alu_ctrl   = rst ? alu : 4'b0000;
   assign bus.instr_done = rst && retire;
   assign bus.retired    = rst ? retired_q : '0;
   assign bus.state_dbg  = state;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-scenario tasks with inline output checks plus an
// instr_done scoreboard holding {expected cycle count, expected retired value}.
`timescale 1ns/1ps
module tb_cpu_control_fsm;
   localparam int WW = 4;

   localparam logic [15:0] C_PC   = 16'h8000;
   localparam logic [15:0] C_IR   = 16'h4000;
   localparam logic [15:0] C_RD   = 16'h2000;
   localparam logic [15:0] C_RW   = 16'h1000;
   localparam logic [15:0] C_AS   = 16'h0800;
   localparam logic [15:0] C_BR   = 16'h0400;
   localparam logic [15:0] C_J    = 16'h0200;
   localparam logic [15:0] C_MW   = 16'h0100;
   localparam logic [15:0] C_MR   = 16'h0080;
   localparam logic [15:0] C_M2R  = 16'h0040;
   localparam logic [15:0] A_AND  = 16'h0000;
   localparam logic [15:0] A_ADD  = 16'h0004;
   localparam logic [15:0] A_OR   = 16'h0008;
   localparam logic [15:0] A_SUB  = 16'h000C;
   localparam logic [15:0] A_SLT  = 16'h0010;
   localparam logic [15:0] C_ILL  = 16'h0002;
   localparam logic [15:0] C_DONE = 16'h0001;
   localparam logic [15:0] E_FETCH = C_PC | C_IR | A_ADD;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst_w = 1'b0;
   always #5 clk = ~clk;

   cpu_control_fsm_if #(.RCNT_W(16)) ifc ();
   cpu_control_fsm_if #(.RCNT_W(WW)) ifw ();

   cpu_control_fsm #(.RCNT_W(16)) dut   (.clk(clk), .rst(rst),   .bus(ifc));
   cpu_control_fsm #(.RCNT_W(WW)) dut_w (.clk(clk), .rst(rst_w), .bus(ifw));

   logic [15:0] ctl;
   assign ctl = {ifc.pc_write, ifc.ir_write, ifc.reg_dst, ifc.reg_write, ifc.alu_src,
                 ifc.branch, ifc.jump, ifc.mem_write, ifc.mem_req, ifc.mem_to_reg,
                 ifc.alu_ctrl, ifc.illegal_op, ifc.instr_done};

   int compared = 0;
   int failed = 0;
   int model_ret = 0;
   logic [15:0] exp_c;
   logic [23:0] exp_q[$];

   // ---------------- scoreboard monitor ----------------
   logic [23:0] sb_e;
   logic [15:0] sb_ret;
   bit sb_chk = 1'b0;
   int cyc = 0;
   int start_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (sb_chk) begin
         sb_chk = 1'b0;
         compared++;
         if (ifc.retired !== sb_ret) begin
            failed++;
            $display("FAIL sb_retired: got %0d want %0d", ifc.retired, sb_ret);
         end
      end
      if (ifc.ir_write) start_cyc = cyc;
      if (ifc.instr_done) begin
         compared++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL sb_unexpected_retire: got instr_done=1 want no retire");
         end else begin
            sb_e = exp_q.pop_front();
            if (8'(cyc - start_cyc + 1) !== sb_e[23:16]) begin
               failed++;
               $display("FAIL sb_cycles: got %0d want %0d", cyc - start_cyc + 1, sb_e[23:16]);
            end
            sb_ret = sb_e[15:0];
            sb_chk = 1'b1;
         end
      end
   end

   // ---------------- driver helpers ----------------
   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rnd6();
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic e, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr);
      ifc.en = e; ifc.opcode = op; ifc.funct = fn; ifc.zero = z; ifc.mem_ready = mr;
      #1;
   endtask

   task automatic push_exp(input int ncyc);
      model_ret++;
      exp_q.push_back({8'(ncyc), 16'(model_ret)});
   endtask

   function automatic logic [5:0] fn_of(input int i);
      case (i)
         0: return 6'b100000;
         1: return 6'b100010;
         2: return 6'b100100;
         3: return 6'b100101;
         default: return 6'b101010;
      endcase
   endfunction

   function automatic logic [15:0] alu_of(input int i);
      case (i)
         0: return A_ADD;
         1: return A_SUB;
         2: return A_AND;
         3: return A_OR;
         default: return A_SLT;
      endcase
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
      step(); step(); #1;
      compared++;
      if (ctl !== 16'h0000) begin failed++; $display("FAIL reset_outputs: got %h want 0000", ctl); end
      compared++;
      if (ifc.retired !== 16'd0) begin failed++; $display("FAIL reset_retired: got %0d want 0", ifc.retired); end
      rst = 1'b1; #1;
      compared++;
      if (ctl !== E_FETCH) begin failed++; $display("FAIL reset_release_fetch: got %h want %h", ctl, E_FETCH); end
      model_ret = 0;
      exp_q.delete();
   endtask

   task automatic test_rtype();
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, OP_R, fn_of(i), rnd(), rnd());
         compared++;
         if (ctl !== E_FETCH) begin failed++; $display("FAIL rtype_fetch: got %h want %h", ctl, E_FETCH); end
         push_exp(4);
         step(); drv(1'b1, OP_R, fn_of(i), rnd(), rnd());
         compared++;
         if (ctl !== 16'h0000) begin failed++; $display("FAIL rtype_decode: got %h want 0000", ctl); end
         step(); drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
         exp_c = C_RD | alu_of(i);
         compared++;
         if (ctl !== exp_c) begin failed++; $display("FAIL rtype_exec%0d: got %h want %h", i, ctl, exp_c); end
         step(); drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
         exp_c = C_RW | C_RD | C_DONE;
         compared++;
         if (ctl !== exp_c) begin failed++; $display("FAIL rtype_wb: got %h want %h", ctl, exp_c); end
         step();
         compared++;
         if (ifc.retired !== 16'(model_ret)) begin failed++; $display("FAIL rtype_retired: got %0d want %0d", ifc.retired, model_ret); end
      end
   endtask

   task automatic test_mem_stall();
      for (int s = 0; s < 2; s++) begin
         logic [5:0] op;
         op = (s == 1) ? OP_SW : OP_LW;
         drv(1'b1, op, rnd6(), rnd(), rnd());
         push_exp((s == 1) ? 7 : 8);
         step(); drv(1'b1, op, rnd6(), rnd(), rnd());
         step(); drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
         compared++;
         if (ctl !== (C_AS | A_ADD)) begin failed++; $display("FAIL mem_exec: got %h want %h", ctl, C_AS | A_ADD); end
         for (int k = 0; k < 4; k++) begin
            step(); drv(1'b1, rnd6(), rnd6(), rnd(), 1'(k == 3));
            exp_c = C_MR | C_AS | ((s == 1) ? C_MW : 16'h0) | ((s == 1 && k == 3) ? C_DONE : 16'h0);
            compared++;
            if (ctl !== exp_c) begin failed++; $display("FAIL mem_phase%0d_%0d: got %h want %h", s, k, ctl, exp_c); end
         end
         if (s == 0) begin
            step(); drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
            exp_c = C_RW | C_M2R | C_DONE;
            compared++;
            if (ctl !== exp_c) begin failed++; $display("FAIL lw_wb: got %h want %h", ctl, exp_c); end
         end
         step();
      end
   endtask

   task automatic test_branch_jump();
      for (int t = 0; t < 3; t++) begin
         logic [5:0] op;
         logic z;
         op = (t == 2) ? OP_J : OP_BEQ;
         z  = (t == 0) ? 1'b1 : (t == 1) ? 1'b0 : rnd();
         drv(1'b1, op, rnd6(), rnd(), rnd());
         push_exp(3);
         step(); drv(1'b1, op, rnd6(), rnd(), rnd());
         step(); drv(1'b1, rnd6(), rnd6(), z, rnd());
         if (t == 2) exp_c = C_J | C_PC | C_DONE;
         else        exp_c = C_BR | A_SUB | C_DONE | (z ? C_PC : 16'h0);
         compared++;
         if (ctl !== exp_c) begin failed++; $display("FAIL branch_exec%0d: got %h want %h", t, ctl, exp_c); end
         step();
      end
   endtask

   task automatic test_en_hold();
      int base;
      base = model_ret;
      for (int k = 0; k < 2; k++) begin
         drv(1'b0, OP_ADDI, rnd6(), rnd(), rnd());
         compared++;
         if (ctl !== A_ADD) begin failed++; $display("FAIL hold_fetch: got %h want %h", ctl, A_ADD); end
         step();
      end
      drv(1'b1, OP_ADDI, rnd6(), rnd(), rnd());
      push_exp(10);
      step(); drv(1'b1, OP_ADDI, rnd6(), rnd(), rnd());
      step();
      for (int k = 0; k < 5; k++) begin
         drv(1'b0, rnd6(), rnd6(), rnd(), rnd());
         compared++;
         if (ctl !== (C_AS | A_ADD)) begin failed++; $display("FAIL hold_exec: got %h want %h", ctl, C_AS | A_ADD); end
         compared++;
         if (ifc.retired !== 16'(base)) begin failed++; $display("FAIL hold_retired: got %0d want %0d", ifc.retired, base); end
         step();
      end
      drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
      compared++;
      if (ctl !== (C_AS | A_ADD)) begin failed++; $display("FAIL hold_exec_resume: got %h want %h", ctl, C_AS | A_ADD); end
      step(); drv(1'b0, rnd6(), rnd6(), rnd(), rnd());
      compared++;
      if (ctl !== 16'h0000) begin failed++; $display("FAIL hold_wb_gated: got %h want 0000", ctl); end
      step(); drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
      compared++;
      if (ctl !== (C_RW | C_DONE)) begin failed++; $display("FAIL hold_wb: got %h want %h", ctl, C_RW | C_DONE); end
      step();
      compared++;
      if (ifc.retired !== 16'(base + 1)) begin failed++; $display("FAIL hold_retired_end: got %0d want %0d", ifc.retired, base + 1); end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 12; n++) begin
         int sel, st, ncyc;
         logic [5:0] op, fn;
         sel = $urandom_range(0, 5);
         st  = 0;
         fn  = fn_of($urandom_range(0, 4));
         case (sel)
            0: begin op = OP_R;    ncyc = 4; end
            1: begin op = OP_ADDI; ncyc = 4; end
            2: begin op = OP_BEQ;  ncyc = 3; end
            3: begin op = OP_J;    ncyc = 3; end
            4: begin op = OP_LW;   st = $urandom_range(0, 2); ncyc = 5 + st; end
            default: begin op = OP_SW; st = $urandom_range(0, 2); ncyc = 4 + st; end
         endcase
         push_exp(ncyc);
         for (int c = 0; c < ncyc; c++) begin
            logic mr;
            if (c >= 3 && c < 3 + st) mr = 1'b0;
            else if (c == 3 + st)     mr = 1'b1;
            else                      mr = rnd();
            if (c < 2) drv(1'b1, op, fn, rnd(), mr);
            else       drv(1'b1, rnd6(), rnd6(), rnd(), mr);
            step();
         end
      end
      compared++;
      if (ifc.retired !== 16'(model_ret)) begin failed++; $display("FAIL b2b_retired: got %0d want %0d", ifc.retired, model_ret); end
   endtask

   task automatic test_reset_mid();
      drv(1'b1, OP_LW, rnd6(), rnd(), rnd());
      step(); drv(1'b1, OP_LW, rnd6(), rnd(), rnd());
      step(); drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
      rst = 1'b0;
      step(); #1;
      compared++;
      if (ctl !== 16'h0000 || ifc.retired !== 16'd0) begin
         failed++; $display("FAIL reset_mid: got %h/%0d want 0000/0", ctl, ifc.retired);
      end
      rst = 1'b1; #1;
      model_ret = 0;
      compared++;
      if (ctl !== E_FETCH) begin failed++; $display("FAIL reset_mid_fetch: got %h want %h", ctl, E_FETCH); end
   endtask

   task automatic test_trap();
      for (int t = 0; t < 2; t++) begin
         logic [5:0] op, fn;
         op = (t == 0) ? 6'b111111 : OP_R;
         fn = (t == 0) ? rnd6() : 6'b000111;
         drv(1'b1, op, fn, rnd(), rnd());
         step(); drv(1'b1, op, fn, rnd(), rnd());
         for (int k = 0; k < 20; k++) begin
            step(); drv(rnd(), rnd6(), rnd6(), rnd(), rnd());
            compared++;
            if (ctl !== C_ILL || ifc.retired !== 16'(model_ret)) begin
               failed++; $display("FAIL trap%0d_hold: got %h/%0d want %h/%0d", t, ctl, ifc.retired, C_ILL, model_ret);
            end
         end
         rst = 1'b0;
         step(); #1;
         compared++;
         if (ctl !== 16'h0000) begin failed++; $display("FAIL trap_reset: got %h want 0000", ctl); end
         drv(1'b1, rnd6(), rnd6(), rnd(), rnd());
         rst = 1'b1; #1;
         model_ret = 0;
         compared++;
         if (ctl !== E_FETCH) begin failed++; $display("FAIL trap_clear_fetch: got %h want %h", ctl, E_FETCH); end
      end
   endtask

   task automatic test_wrap();
      logic [WW-1:0] exp_w;
      ifw.en = 1'b1; ifw.opcode = OP_J; ifw.funct = 6'd0; ifw.zero = 1'b0; ifw.mem_ready = 1'b0;
      rst_w = 1'b0;
      step();
      rst_w = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step(); step(); step();
         exp_w = WW'(k);
         compared++;
         if (ifw.retired !== exp_w) begin failed++; $display("FAIL wrap_count%0d: got %0d want %0d", k, ifw.retired, exp_w); end
      end
   endtask

   initial begin
      ifw.en = 1'b0; ifw.opcode = 6'd0; ifw.funct = 6'd0; ifw.zero = 1'b0; ifw.mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_mem_stall();
      test_branch_jump();
      test_en_hold();
      test_back_to_back();
      test_reset_mid();
      test_trap();
      test_wrap();
      step(); step();
      compared++;
      if (exp_q.size() != 0) begin failed++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
